// File: rtl/ahb_lite_fir_ntap.sv
// AHB-Lite zero-wait-state slave around an N-tap FIR: sample FIFO, one shared
// signed MAC stepping one tap per cycle, saturate/wrap output scaling.
`timescale 1ns/1ps
module ahb_lite_fir_ntap #(
  parameter int NTAPS      = 4,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hsize,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [DW-1:0]     hwdata,
  output logic [DW-1:0]     hrdata,
  output logic              hresp
);
  localparam int TW    = $clog2(NTAPS);
  localparam int AW    = 2*DW + TW;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int A_END = 8 + 2*NTAPS;
  localparam logic [ADDR_W-2:0] W_STATUS = (ADDR_W-1)'(0);
  localparam logic [ADDR_W-2:0] W_RESULT = (ADDR_W-1)'(1);
  localparam logic [ADDR_W-2:0] W_SAMPLE = (ADDR_W-1)'(2);
  localparam logic [ADDR_W-2:0] W_CTRL   = (ADDR_W-1)'(3);
  localparam logic [ADDR_W-2:0] W_COEFF  = (ADDR_W-1)'(4);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  function automatic logic bad_access(input logic [ADDR_W-1:0] a, input logic wr, input logic sz);
    return (int'(a) >= A_END) || (sz && a[0]) || (wr && (a[ADDR_W-1:1] < W_SAMPLE));
  endfunction

  function automatic logic [DW-1:0] lane_mask(input logic sz, input logic odd);
    logic [DW-1:0] lo;
    lo = {{(DW-8){1'b0}}, 8'hFF};
    if (sz) return '1;
    return odd ? ~lo : lo;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [DW-1:0] m);
    return (old & ~m) | (nw & m);
  endfunction

  // Returns {overflow, value}: arithmetic shift by DW-1, then clamp or wrap.
  function automatic logic [DW:0] scale(input logic signed [AW-1:0] a, input logic sat_mode);
    logic signed [AW-1:0] sh;
    logic                 ovf;
    sh  = a >>> (DW-1);
    ovf = !((&sh[AW-1:DW-1]) || !(|sh[AW-1:DW-1]));
    if (ovf && sat_mode) return {1'b1, sh[AW-1], {(DW-1){~sh[AW-1]}}};
    return {ovf, sh[DW-1:0]};
  endfunction

  logic                 vld_p1, write_p1, size_p1;
  logic [ADDR_W-1:0]    addr_p1;
  logic [ADDR_W-2:0]    word_p1, rd_word;
  logic [TW-1:0]        cidx_p1;
  logic                 enable, sat, err, clr;
  logic [DW-1:0]        result, last_sample, status, ctrl_rd, rd_val, fwd_val;
  logic [DW-1:0]        wmask, sample_new, ctrl_new, coeff_new;
  logic signed [DW-1:0] coeff [NTAPS];
  logic signed [DW-1:0] hist [NTAPS];
  logic [DW-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 fifo_full, fifo_empty, push, pop;
  logic                 dp_bad, dp_wr, busy, mac_en, load_res;
  logic signed [AW-1:0] acc;
  logic [TW-1:0]        tap;
  logic signed [2*DW-1:0] h_ext, c_ext, prod;
  logic [DW:0]          scaled;
  state_t               state, state_nxt;
  logic                 unused_htrans0;

  assign unused_htrans0 = htrans[0];

  // Stage p1: address phase captured, executed during the data phase
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= hsel && htrans[1];
    addr_p1  <= haddr;
    write_p1 <= hwrite;
    size_p1  <= hsize;
  end

  assign word_p1    = addr_p1[ADDR_W-1:1];
  assign cidx_p1    = TW'(word_p1 - W_COEFF);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign wmask      = lane_mask(size_p1, addr_p1[0]);
  assign ctrl_rd    = {{(DW-3){1'b0}}, sat, 1'b0, enable};
  assign sample_new = merge('0, hwdata, wmask);
  assign ctrl_new   = merge(ctrl_rd, hwdata, wmask);
  assign coeff_new  = merge(coeff[cidx_p1], hwdata, wmask);
  assign dp_bad     = bad_access(addr_p1, write_p1, size_p1)
                   || (write_p1 && word_p1 == W_SAMPLE && fifo_full)
                   || (write_p1 && word_p1 >= W_COEFF && busy);
  assign hresp      = vld_p1 && dp_bad;
  assign dp_wr      = vld_p1 && write_p1 && !dp_bad;
  assign push       = dp_wr && word_p1 == W_SAMPLE;
  assign clr        = dp_wr && word_p1 == W_CTRL && ctrl_new[1];

  always_comb begin
    status         = '0;
    status[0]      = busy;
    status[1]      = err;
    status[2]      = fifo_full;
    status[3]      = fifo_empty;
    status[8 +: CW] = count;
  end

  always_comb begin
    case (word_p1)
      W_SAMPLE: fwd_val = sample_new;
      W_CTRL:   fwd_val = {{(DW-3){1'b0}}, ctrl_new[2], 1'b0, ctrl_new[0]};
      default:  fwd_val = coeff_new;
    endcase
  end

  // A write still in its data phase is merged into a same-register read.
  always_comb begin
    rd_word = haddr[ADDR_W-1:1];
    case (rd_word)
      W_STATUS: rd_val = status;
      W_RESULT: rd_val = result;
      W_SAMPLE: rd_val = last_sample;
      W_CTRL:   rd_val = ctrl_rd;
      default:  rd_val = coeff[TW'(rd_word - W_COEFF)];
    endcase
    if (dp_wr && word_p1 == rd_word) rd_val = fwd_val;
    if (bad_access(haddr, 1'b0, hsize)) rd_val = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)                            hrdata <= '0;
    else if (hsel && htrans[1] && !hwrite) hrdata <= rd_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable      <= 1'b0;
      sat         <= 1'b0;
      last_sample <= '0;
      for (int i = 0; i < NTAPS; i++) coeff[i] <= '0;
    end else if (dp_wr) begin
      case (word_p1)
        W_SAMPLE: last_sample <= sample_new;
        W_CTRL: begin
          enable <= ctrl_new[0];
          sat    <= ctrl_new[2];
        end
        default: if (word_p1 >= W_COEFF) coeff[cidx_p1] <= coeff_new;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sample_new;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && !fifo_empty) state_nxt = MAC;
      MAC:     if (tap == TW'(NTAPS-1))   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    pop      = (state == IDLE) && enable && !fifo_empty;
    mac_en   = (state == MAC);
    load_res = (state == DONE);
  end

  // Stage MAC: one tap product per cycle into the wide accumulator
  assign h_ext  = {{DW{hist[tap][DW-1]}}, hist[tap]};
  assign c_ext  = {{DW{coeff[tap][DW-1]}}, coeff[tap]};
  assign prod   = h_ext * c_ext;
  assign scaled = scale(acc, sat);

  always_ff @(posedge clk) begin
    if (pop) begin
      acc <= '0;
      tap <= '0;
    end else if (mac_en) begin
      acc <= acc + {{TW{prod[2*DW-1]}}, prod};
      tap <= tap + TW'(1);
    end
  end

  // Stage DONE: scaled accumulator lands in RESULT
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < NTAPS; i++) hist[i] <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      if (pop) begin
        for (int i = NTAPS-1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= fifo_mem[rd_ptr];
      end
      if (load_res) begin
        result <= scaled[DW-1:0];
        if (scaled[DW]) err <= 1'b1;
      end
    end
  end
endmodule
